vfp_config_axi4lite_master: RTL and testbench
=============================================

// Module: vfp_config_axi4lite_master
// PURPOSE
//  AXI4-Lite initiator that drives the vfpconfig_* register slave of VFP_v1_0 from a simple command/response port.
//  The testbench sequencer or on-chip boot logic issues one register write or read at a time.
//  The block runs the full AW/W/B or AR/R handshake and returns data and status.
//  It sits between the config sequencer and the vfpconfig slave, on the clkmm domain.
// PARAMETERS
//  C_vfpConfig_ADDR_WIDTH  8     AXI address width (byte address)
//  C_vfpConfig_DATA_WIDTH  32    AXI data width; WSTRB width = DATA_WIDTH/8
//  TIMEOUT_CYCLES          1024  watchdog limit in cycles (used only with VFP_CFG_TIMEOUT_EN)
// PORTS
//  vfpconfig_aclk     in   1     clock; all logic is rising-edge
//  vfpconfig_aresetn  in   1     asynchronous active-low reset
//  cmd_valid          in   1     command request
//  cmd_ready          out  1     command accepted when cmd_valid & cmd_ready
//  cmd_write          in   1     1=write, 0=read
//  cmd_addr           in   AW    register byte address
//  cmd_wdata          in   DW    write data
//  cmd_wstrb          in   DW/8  write byte strobes
//  rsp_valid          out  1     response available
//  rsp_ready          in   1     response consumed when rsp_valid & rsp_ready
//  rsp_rdata          out  DW    read data (0 for writes)
//  rsp_resp           out  2     BRESP/RRESP, or 2'b10 on timeout
//  rsp_timeout        out  1     transaction aborted by watchdog
//  m_awaddr/awprot/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready,
//  m_araddr/arprot/arvalid/arready, m_rdata/rresp/rvalid/rready
//                     AXI4-Lite master channels; widths match vfpconfig_* slave ports
// BEHAVIOUR
//  - Reset values: all *valid outputs, bready, rready, cmd_ready, rsp_valid and rsp_timeout are 0.
//    All address, data and resp outputs are 0. FSM state is IDLE.
//  - FSM states: IDLE, WR (AW+W), WB (B wait), RA (AR), RD (R wait), RSP.
//  - IDLE: cmd_ready=1. On accept, the command fields are registered.
//    Next cycle: cmd_write=1 goes to WR with awvalid=wvalid=1; cmd_write=0 goes to RA with arvalid=1.
//  - WR: awvalid and wvalid drop independently, each on the cycle its ready is sampled high.
//    Either order, or same cycle, is legal. Once both handshakes are done, go to WB with bready=1.
//  - WB: on bvalid, capture bresp, set bready=0, rsp_rdata=0, go to RSP.
//  - RA: on arready, set arvalid=0, rready=1, go to RD.
//  - RD: on rvalid, capture rdata/rresp, set rready=0, go to RSP.
//  - RSP: rsp_valid=1 and held, fields stable, until rsp_ready; then return to IDLE.
//    If rsp_ready is already high on entry, rsp_valid lasts one cycle.
//  - Only one transaction is outstanding; cmd_ready=0 outside IDLE.
//  - Minimum latency from cmd accept to rsp_valid, with zero-wait slave: write 3 cycles, read 3 cycles.
//  - Valid outputs never drop before their ready is seen, except on watchdog abort.
//  - awprot=arprot=3'b000. Address and data are held constant while valid.
//  - Asynchronous reset mid-transaction drops all valids immediately and returns to IDLE.
//    No response is generated; the slave is reset by the same aresetn.
// CONFIGURATION
//  - VFP_CFG_TIMEOUT_EN defined: a counter runs in WR/WB/RA/RD and clears on each state entry.
//    When it reaches TIMEOUT_CYCLES, all valid/ready outputs are forced to 0 and the FSM goes to RSP.
//    The response carries rsp_resp=2'b10 and rsp_timeout=1. This abort is a bench/debug aid only.
//  - VFP_CFG_TIMEOUT_EN not defined: there is no counter, the FSM waits indefinitely, and rsp_timeout is tied 0.
// TESTING
//  1. Write 0x04<=0x000000A5, wstrb 4'hF; awready at once, wready after 3 cycles.
//     -> exactly one AW and one W handshake; rsp_resp=00, rsp_rdata=0.
//  2. Read 0x08; arready after 1 cycle, rvalid with 0x12345678/RRESP=00 after 2 more.
//     -> rsp_rdata=0x12345678, rsp_resp=00.
//  3. Write then read 0x0C back-to-back with zero-wait slave.
//     -> cmd_ready low while busy; readback equals the written value; 3-cycle latency each.
//  4. Hold rsp_ready=0 for 5 cycles after a read.
//     -> rsp_valid and rsp_rdata stable for 5 cycles, then IDLE with cmd_ready=1.
//  5. Assert aresetn=0 while in WB.
//     -> all valids and bready=0 immediately; after release, cmd_ready=1 and no rsp_valid.
//  6. (VFP_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16) Read where the slave never asserts arready.
//     -> after 16 cycles arvalid=0, rsp_valid=1, rsp_resp=10, rsp_timeout=1.

Source files
------------

// File: rtl/vfp_config_axi4lite_master.sv
// AXI4-Lite initiator for the VFP_v1_0 vfpconfig register slave.
// Accepts one register write or read on a command port, runs the AW/W/B or
// AR/R handshakes and returns data and status on a response port.
// Optional watchdog abort is enabled with `define VFP_CFG_TIMEOUT_EN.
module vfp_config_axi4lite_master #(
    parameter int C_vfpConfig_ADDR_WIDTH = 8,
    parameter int C_vfpConfig_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES         = 1024
) (
    input  logic                                  vfpconfig_aclk,
    input  logic                                  vfpconfig_aresetn,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_write,
    input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_vfpConfig_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                            rsp_resp,
    output logic                                  rsp_timeout,
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                            m_awprot,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [C_vfpConfig_DATA_WIDTH-1:0]     m_wdata,
    output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    input  logic [1:0]                            m_bresp,
    input  logic                                  m_bvalid,
    output logic                                  m_bready,
    output logic [C_vfpConfig_ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                            m_arprot,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    input  logic [C_vfpConfig_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                            m_rresp,
    input  logic                                  m_rvalid,
    output logic                                  m_rready
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP} state_t;

    state_t                              state, state_nxt;
    logic                                cmd_ready_nxt, rsp_valid_nxt;
    logic                                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [C_vfpConfig_DATA_WIDTH-1:0]   rdata_nxt;
    logic [1:0]                          resp_nxt;
    logic                                accept;
    logic                                abort;

    assign accept   = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

`ifdef VFP_CFG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             busy;
    logic             timeout_nxt;

    assign busy  = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);
    assign abort = busy && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts cycles spent in the current busy state; restarts on every state change
    always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
        if (!vfpconfig_aresetn)                wd_cnt <= '0;
        else if (!busy || state_nxt != state)  wd_cnt <= '0;
        else                                   wd_cnt <= wd_cnt + 1'b1;
    end

    // Timeout flag is set by an abort and held through RSP until the port is idle again
    always_comb begin
        timeout_nxt = rsp_timeout;
        if (abort)                        timeout_nxt = 1'b1;
        else if (state_nxt == S_IDLE)     timeout_nxt = 1'b0;
    end

    // Timeout status register
    always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
        if (!vfpconfig_aresetn) rsp_timeout <= 1'b0;
        else                    rsp_timeout <= timeout_nxt;
    end
`else
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Next-state and next registered-output values; every output is a flop so reset forces all to 0
    always_comb begin
        state_nxt   = state;
        awvalid_nxt = m_awvalid;
        wvalid_nxt  = m_wvalid;
        bready_nxt  = m_bready;
        arvalid_nxt = m_arvalid;
        rready_nxt  = m_rready;
        rdata_nxt   = rsp_rdata;
        resp_nxt    = rsp_resp;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        state_nxt   = S_WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_RA;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR: begin
                awvalid_nxt = m_awvalid & ~m_awready;
                wvalid_nxt  = m_wvalid & ~m_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    state_nxt  = S_WB;
                    bready_nxt = 1'b1;
                end
            end
            S_WB: begin
                if (m_bvalid) begin
                    bready_nxt = 1'b0;
                    rdata_nxt  = '0;
                    resp_nxt   = m_bresp;
                    state_nxt  = S_RSP;
                end
            end
            S_RA: begin
                if (m_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_RD;
                end
            end
            S_RD: begin
                if (m_rvalid) begin
                    rready_nxt = 1'b0;
                    rdata_nxt  = m_rdata;
                    resp_nxt   = m_rresp;
                    state_nxt  = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            awvalid_nxt = 1'b0;
            wvalid_nxt  = 1'b0;
            bready_nxt  = 1'b0;
            arvalid_nxt = 1'b0;
            rready_nxt  = 1'b0;
            rdata_nxt   = '0;
            resp_nxt    = 2'b10;
            state_nxt   = S_RSP;
        end
        cmd_ready_nxt = (state_nxt == S_IDLE);
        rsp_valid_nxt = (state_nxt == S_RSP);
    end

    // State and handshake/response registers
    always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
        if (!vfpconfig_aresetn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            m_awvalid <= awvalid_nxt;
            m_wvalid  <= wvalid_nxt;
            m_bready  <= bready_nxt;
            m_arvalid <= arvalid_nxt;
            m_rready  <= rready_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_resp  <= resp_nxt;
        end
    end

    // Command fields are captured on accept and held until the next command
    always_ff @(posedge vfpconfig_aclk or negedge vfpconfig_aresetn) begin
        if (!vfpconfig_aresetn) begin
            m_awaddr <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            m_araddr <= '0;
        end else if (accept) begin
            if (cmd_write) begin
                m_awaddr <= cmd_addr;
                m_wdata  <= cmd_wdata;
                m_wstrb  <= cmd_wstrb;
            end else begin
                m_araddr <= cmd_addr;
            end
        end
    end

endmodule

// File: tb/tb_vfp_config_axi4lite_master.sv
// Self-checking bench for vfp_config_axi4lite_master.
// A cycle-stepped AXI4-Lite slave with programmable wait states sits in the
// bench; expected read data comes from a separate word-array model updated
// from the command stream. Define VFP_CFG_TIMEOUT_EN to add the watchdog test.
module tb_vfp_config_axi4lite_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
    logic        s_arready = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = '0, s_rresp = '0;
    logic [31:0] s_rdata = '0;

    logic [31:0] slave_mem [64];
    logic [31:0] model_mem [64];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vfp_config_axi4lite_master #(
        .C_vfpConfig_ADDR_WIDTH(8),
        .C_vfpConfig_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .vfpconfig_aclk(clk), .vfpconfig_aresetn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(s_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(s_wready),
        .m_bresp(s_bresp), .m_bvalid(s_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(s_arready),
        .m_rdata(s_rdata), .m_rresp(s_rresp), .m_rvalid(s_rvalid), .m_rready(m_rready)
    );

    // One complete transaction: drives the command, plays the slave, consumes the response.
    task automatic do_txn(input string tag, input bit wr, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input int rsp_d,
                          input logic [1:0] resp_sel, input bit chk_lat);
        int cyc, acc_cyc, rsp_first, n, held;
        int aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_cnt, w_cnt, ar_cnt;
        bit accepted, done, rsp_seen, b_sent, r_sent, busy_viol, proto_viol, prot_bad;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit p_awv, p_wv, p_arv, p_br, p_rr, p_aw_hs, p_w_hs, p_ar_hs, p_b_hs, p_r_hs;
        logic [7:0]  p_awaddr, p_araddr, cap_awaddr, cap_araddr;
        logic [31:0] p_wdata, cap_wdata, got_rdata, exp_rdata;
        logic [3:0]  p_wstrb, cap_wstrb;
        logic [1:0]  got_resp;
        logic        got_to;

        exp_rdata = wr ? 32'h0 : model_mem[addr[7:2]];
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s cmd_ready_idle got %b exp 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        rsp_ready = (rsp_d == 0);
        cyc = 0; acc_cyc = 0; rsp_first = 0; held = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        accepted = 0; done = 0; rsp_seen = 0; b_sent = 0; r_sent = 0;
        busy_viol = 0; proto_viol = 0; prot_bad = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
        p_aw_hs = 0; p_w_hs = 0; p_ar_hs = 0; p_b_hs = 0; p_r_hs = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0; cap_wstrb = '0;
        got_rdata = '0; got_resp = '0; got_to = 1'b0;

        while (!done && cyc < 300) begin
            if (!accepted) begin
                if (cmd_ready === 1'b1) begin
                    accepted = 1;
                    acc_cyc  = cyc;
                end
            end else begin
                cmd_valid = 1'b0;
                if (cmd_ready !== 1'b0) busy_viol = 1;
            end

            if (p_awv && !p_aw_hs && !m_awvalid) proto_viol = 1;
            if (p_wv  && !p_w_hs  && !m_wvalid)  proto_viol = 1;
            if (p_arv && !p_ar_hs && !m_arvalid) proto_viol = 1;
            if (p_br  && !p_b_hs  && !m_bready)  proto_viol = 1;
            if (p_rr  && !p_r_hs  && !m_rready)  proto_viol = 1;
            if (p_awv && m_awvalid && m_awaddr !== p_awaddr) proto_viol = 1;
            if (p_wv  && m_wvalid  && (m_wdata !== p_wdata || m_wstrb !== p_wstrb)) proto_viol = 1;
            if (p_arv && m_arvalid && m_araddr !== p_araddr) proto_viol = 1;
            if (m_awprot !== 3'b000 || m_arprot !== 3'b000) prot_bad = 1;

            if (aw_cnt >= 1 && w_cnt >= 1 && !b_sent) begin
                if (b_wait >= b_d) begin
                    s_bvalid = 1'b1; s_bresp = resp_sel;
                end else begin
                    s_bvalid = 1'b0; b_wait++;
                end
            end else s_bvalid = 1'b0;
            b_hs = s_bvalid && m_bready;
            if (b_hs) begin
                b_sent = 1;
                for (int i = 0; i < 4; i++)
                    if (cap_wstrb[i]) slave_mem[cap_awaddr[7:2]][8*i +: 8] = cap_wdata[8*i +: 8];
            end

            if (ar_cnt >= 1 && !r_sent) begin
                if (r_wait >= r_d) begin
                    s_rvalid = 1'b1; s_rresp = resp_sel; s_rdata = slave_mem[cap_araddr[7:2]];
                end else begin
                    s_rvalid = 1'b0; r_wait++;
                end
            end else s_rvalid = 1'b0;
            r_hs = s_rvalid && m_rready;
            if (r_hs) r_sent = 1;

            s_awready = m_awvalid && (aw_wait >= aw_d);
            aw_hs = m_awvalid && s_awready;
            if (m_awvalid && !aw_hs) aw_wait++;
            if (aw_hs) begin aw_cnt++; cap_awaddr = m_awaddr; end
            s_wready = m_wvalid && (w_wait >= w_d);
            w_hs = m_wvalid && s_wready;
            if (m_wvalid && !w_hs) w_wait++;
            if (w_hs) begin w_cnt++; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
            s_arready = m_arvalid && (ar_wait >= ar_d);
            ar_hs = m_arvalid && s_arready;
            if (m_arvalid && !ar_hs) ar_wait++;
            if (ar_hs) begin ar_cnt++; cap_araddr = m_araddr; end

            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1; rsp_first = cyc;
                    got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
                end else if (rsp_rdata !== got_rdata || rsp_resp !== got_resp || rsp_timeout !== got_to)
                    proto_viol = 1;
                held++;
                if (cyc - rsp_first >= rsp_d) rsp_ready = 1'b1;
                if (rsp_ready) done = 1;
            end

            p_awv = m_awvalid; p_wv = m_wvalid; p_arv = m_arvalid; p_br = m_bready; p_rr = m_rready;
            p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs; p_b_hs = b_hs; p_r_hs = r_hs;
            p_awaddr = m_awaddr; p_araddr = m_araddr; p_wdata = m_wdata; p_wstrb = m_wstrb;
            @(negedge clk);
            cyc++;
        end
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0; s_bvalid = 1'b0; s_rvalid = 1'b0;
        cmd_valid = 1'b0;

        tests++;
        if (!done) begin fails++; $display("FAIL %s completion got 0 exp 1 (no response in 300 cycles)", tag); end
        tests++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            fails++; $display("FAIL %s post_rsp {rsp_valid,cmd_ready} got %b exp 01", tag, {rsp_valid, cmd_ready});
        end
        rsp_ready = 1'b0;
        tests++;
        if (got_rdata !== exp_rdata) begin fails++; $display("FAIL %s rsp_rdata got %h exp %h", tag, got_rdata, exp_rdata); end
        tests++;
        if (got_resp !== resp_sel || got_to !== 1'b0) begin
            fails++; $display("FAIL %s resp/timeout got %b/%b exp %b/0", tag, got_resp, got_to, resp_sel);
        end
        tests++;
        if ({aw_cnt[7:0], w_cnt[7:0], ar_cnt[7:0]} !== (wr ? 24'h010100 : 24'h000001)) begin
            fails++; $display("FAIL %s handshakes aw/w/ar got %0d/%0d/%0d exp %0d/%0d/%0d",
                              tag, aw_cnt, w_cnt, ar_cnt, wr, wr, !wr);
        end
        tests++;
        if (wr ? {cap_awaddr, cap_wdata, cap_wstrb} !== {addr, wd, ws} : cap_araddr !== addr) begin
            fails++; $display("FAIL %s channel_payload got %h/%h/%h/%h exp addr %h data %h strb %h",
                              tag, cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, addr, wd, ws);
        end
        tests++;
        if ({busy_viol, proto_viol, prot_bad} !== 3'b000) begin
            fails++; $display("FAIL %s busy/protocol/prot violations got %b exp 000", tag, {busy_viol, proto_viol, prot_bad});
        end
        if (chk_lat) begin
            tests++;
            if (rsp_first - acc_cyc != 3) begin
                fails++; $display("FAIL %s latency got %0d exp 3", tag, rsp_first - acc_cyc);
            end
        end
        tests++;
        if (held != rsp_d + 1) begin fails++; $display("FAIL %s rsp_valid_cycles got %0d exp %0d", tag, held, rsp_d + 1); end

        if (wr && done)
            for (int i = 0; i < 4; i++)
                if (ws[i]) model_mem[addr[7:2]][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, cmd_ready, rsp_valid, rsp_timeout} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got %b exp 00000000",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, cmd_ready, rsp_valid, rsp_timeout});
        end
        tests++;
        if ({m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot, rsp_rdata, rsp_resp} !== '0) begin
            fails++; $display("FAIL reset_data got %h exp 0",
                {m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot, rsp_rdata, rsp_resp});
        end
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_write_basic;
        do_txn("write_basic", 1'b1, 8'h04, 32'h0000_00A5, 4'hF, 0, 3, 0, 0, 0, 0, 2'b00, 1'b0);
    endtask

    task automatic test_read_basic;
        slave_mem[2] = 32'h1234_5678;
        model_mem[2] = 32'h1234_5678;
        do_txn("read_basic", 1'b0, 8'h08, 32'h0, 4'h0, 0, 0, 0, 1, 2, 0, 2'b00, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_txn("b2b_write", 1'b1, 8'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1);
        do_txn("b2b_read", 1'b0, 8'h0C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_rsp_hold;
        do_txn("rsp_hold", 1'b0, 8'h0C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b00, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n;
        bit bad;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        s_awready = 1'b1; s_wready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (m_bready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (m_bready !== 1'b1) begin fails++; $display("FAIL reset_mid reach_wb bready got %b exp 1", m_bready); end
        rstn = 1'b0;
        #1;
        tests++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, cmd_ready} !== 7'h00) begin
            fails++; $display("FAIL reset_mid async_clear got %b exp 0000000",
                {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, cmd_ready});
        end
        s_awready = 1'b0; s_wready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_mid cmd_ready got %b exp 1", cmd_ready); end
        tests++;
        if (bad) begin fails++; $display("FAIL reset_mid spurious_rsp got 1 exp 0"); end
    endtask

    task automatic test_random;
        logic [7:0] a;
        bit w;
        for (int k = 0; k < 40; k++) begin
            w = $urandom_range(0, 1) == 1;
            a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
            do_txn("random", w, a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), 1'b0);
        end
    endtask

`ifdef VFP_CFG_TIMEOUT_EN
    task automatic test_timeout;
        int n, arv_cycles;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h14;
        s_arready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0; arv_cycles = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            if (m_arvalid === 1'b1) arv_cycles++;
            @(negedge clk);
            n++;
        end
        tests++;
        if (arv_cycles != 16) begin fails++; $display("FAIL timeout arvalid_cycles got %0d exp 16", arv_cycles); end
        tests++;
        if ({m_arvalid, rsp_valid, rsp_resp, rsp_timeout} !== 5'b01101) begin
            fails++; $display("FAIL timeout {arvalid,rsp_valid,resp,timeout} got %b exp 01101",
                              {m_arvalid, rsp_valid, rsp_resp, rsp_timeout});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, cmd_ready, rsp_timeout} !== 3'b010) begin
            fails++; $display("FAIL timeout_exit {rsp_valid,cmd_ready,timeout} got %b exp 010",
                              {rsp_valid, cmd_ready, rsp_timeout});
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = $urandom;
            model_mem[i] = slave_mem[i];
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_rsp_hold();
        test_reset_mid();
        test_random();
`ifdef VFP_CFG_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
